instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Single-issue instruction fetch stage: drives a ready/valid instruction memory
// port and feeds the decode register through a one-entry skid buffer.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] Instruction_out,
    output logic        valid_out
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned STEP = 4;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic              redir_pend_q, redir_pend_d;
    logic [XLEN-1:0]   redir_tgt_q, redir_tgt_d;
    logic [XLEN-1:0]   buf_pc_q, buf_pc_d;
    logic [XLEN-1:0]   buf_instr_q, buf_instr_d;
    logic [XLEN-1:0]   pc_out_q, pc_out_d;
    logic [XLEN-1:0]   instr_out_q, instr_out_d;
    logic              valid_q, valid_d;
    logic              transfer;
    logic [XLEN-1:0]   seq_pc;

    assign transfer = req_q & imem_ready;
    assign seq_pc   = fetch_pc_q + XLEN'(STEP);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            req_q        <= 1'b0;
            fetch_pc_q   <= RESET_PC;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= '0;
            buf_pc_q     <= '0;
            buf_instr_q  <= '0;
            pc_out_q     <= '0;
            instr_out_q  <= BUBBLE_INSTR;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            fetch_pc_q   <= fetch_pc_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
            buf_pc_q     <= buf_pc_d;
            buf_instr_q  <= buf_instr_d;
            pc_out_q     <= pc_out_d;
            instr_out_q  <= instr_out_d;
            valid_q      <= valid_d;
        end
    end

    // Next-state logic; branch_taken outranks freeze in every state
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;
        buf_pc_d     = buf_pc_q;
        buf_instr_d  = buf_instr_q;
        pc_out_d     = pc_out_q;
        instr_out_d  = instr_out_q;
        valid_d      = valid_q;

        unique case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    valid_d     = 1'b0;
                    instr_out_d = BUBBLE_INSTR;
                    if (transfer) begin
                        fetch_pc_d   = branch_address;
                        redir_pend_d = 1'b0;
                    end else begin
                        // Address must stay put until the pending request completes
                        redir_pend_d = 1'b1;
                        redir_tgt_d  = branch_address;
                    end
                end else if (transfer && redir_pend_q) begin
                    fetch_pc_d   = redir_tgt_q;
                    redir_pend_d = 1'b0;
                    valid_d      = 1'b0;
                    instr_out_d  = BUBBLE_INSTR;
                end else if (transfer) begin
                    fetch_pc_d = seq_pc;
                    if (freeze) begin
                        buf_pc_d    = seq_pc;
                        buf_instr_d = imem_rdata;
                        state_d     = HOLD;
                    end else begin
                        pc_out_d    = seq_pc;
                        instr_out_d = imem_rdata;
                        valid_d     = 1'b1;
                    end
                end else if (!freeze) begin
                    valid_d     = 1'b0;
                    instr_out_d = BUBBLE_INSTR;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    fetch_pc_d  = branch_address;
                    valid_d     = 1'b0;
                    instr_out_d = BUBBLE_INSTR;
                    state_d     = FETCH;
                end else if (!freeze) begin
                    pc_out_d    = buf_pc_q;
                    instr_out_d = buf_instr_q;
                    valid_d     = 1'b1;
                    state_d     = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        req_d = (state_d == FETCH);
    end

    assign imem_req        = req_q;
    assign imem_addr       = fetch_pc_q;
    assign PC_out          = pc_out_q;
    assign Instruction_out = instr_out_q;
    assign valid_out       = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] BUB      = 32'h0000_0000;
    localparam logic [31:0] SALT     = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] PC_out;
    logic [31:0] Instruction_out;
    logic        valid_out;

    int n_pass  = 0;
    int n_total = 0;

    instruction_fetch_unit #(.RESET_PC(RESET_PC), .BUBBLE_INSTR(BUB)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .branch_taken(branch_taken), .branch_address(branch_address),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .PC_out(PC_out), .Instruction_out(Instruction_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    // Memory: every word is its own address salted
    assign imem_rdata = imem_addr ^ SALT;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    endtask

    // Model state: outstanding request, next fetch address, pending redirect,
    // skid queue of {pc+4, word}, and what decode must see.
    bit          m_init = 1'b0;
    bit          m_req;
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_tgt;
    logic [63:0] skid[$];
    logic [31:0] m_pco, m_ins;
    bit          m_val;

    always @(posedge clk) begin
        bit          xfer;
        logic [31:0] word;
        logic [63:0] e;
        if (rst) begin
            m_init = 1'b1; m_req = 1'b0; m_pc = RESET_PC; m_pend = 1'b0; m_tgt = '0;
            skid.delete(); m_pco = '0; m_ins = BUB; m_val = 1'b0;
        end else if (m_init) begin
            xfer = m_req && imem_ready;
            word = m_pc ^ SALT;
            if (branch_taken) begin
                m_val = 1'b0; m_ins = BUB;
                if (skid.size() != 0) begin skid.delete(); m_pc = branch_address; end
                else if (xfer) begin m_pc = branch_address; m_pend = 1'b0; end
                else begin m_pend = 1'b1; m_tgt = branch_address; end
            end else if (skid.size() != 0) begin
                if (!freeze) begin
                    e = skid.pop_front();
                    m_pco = e[63:32]; m_ins = e[31:0]; m_val = 1'b1;
                end
            end else if (xfer && m_pend) begin
                m_pc = m_tgt; m_pend = 1'b0; m_val = 1'b0; m_ins = BUB;
            end else if (xfer) begin
                if (freeze) skid.push_back({m_pc + 32'd4, word});
                else begin m_pco = m_pc + 32'd4; m_ins = word; m_val = 1'b1; end
                m_pc = m_pc + 32'd4;
            end else if (!freeze) begin
                m_val = 1'b0; m_ins = BUB;
            end
            m_req = (skid.size() == 0);
        end
    end

    // Per-cycle comparison against the model, just after the edge settles
    always @(posedge clk) begin
        #1;
        if (m_init) begin
            check("m_req",   {31'd0, imem_req},  {31'd0, m_req});
            if (m_req) check("m_addr", imem_addr, m_pc);
            check("m_valid", {31'd0, valid_out}, {31'd0, m_val});
            check("m_pc_out", PC_out, m_pco);
            check("m_instr", Instruction_out, m_ins);
        end
    end

    task automatic step(input logic r, input logic f, input logic b,
                        input logic [31:0] ba, input logic rdy);
        @(negedge clk);
        rst = r; freeze = f; branch_taken = b; branch_address = ba; imem_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc, input logic [31:0] ins);
        check({tag, ".req"},   {31'd0, imem_req},  {31'd0, req});
        check({tag, ".addr"},  imem_addr, addr);
        check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
        check({tag, ".pc"},    PC_out, pc);
        check({tag, ".instr"}, Instruction_out, ins);
    endtask

    initial begin
        // Reset values
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 32'h40, 1);
        expect_out("reset", 0, RESET_PC, 0, 32'h0, BUB);

        // Streaming at full rate
        step(0, 0, 0, 0, 1);
        expect_out("first_req", 1, 32'h0, 0, 32'h0, BUB);
        step(0, 0, 0, 0, 1);
        expect_out("stream0", 1, 32'h4, 1, 32'h4, 32'hA5A5A5A5);
        step(0, 0, 0, 0, 1);
        expect_out("stream1", 1, 32'h8, 1, 32'h8, 32'hA5A5A5A1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        expect_out("stream3", 1, 32'h10, 1, 32'h10, 32'hA5A5A5A9);

        // Freeze on the 0x10 transfer
        step(0, 1, 0, 0, 1);
        expect_out("hold0", 0, 32'h14, 1, 32'h10, 32'hA5A5A5A9);
        step(0, 1, 0, 0, 1);
        expect_out("hold1", 0, 32'h14, 1, 32'h10, 32'hA5A5A5A9);
        step(0, 0, 0, 0, 1);
        expect_out("unhold", 1, 32'h14, 1, 32'h14, 32'hA5A5A5B5);
        step(0, 0, 0, 0, 1);
        expect_out("after_hold", 1, 32'h18, 1, 32'h18, 32'hA5A5A5B1);

        // Branch while a request at 0x20 is stalled
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        expect_out("stall", 1, 32'h20, 0, 32'h20, BUB);
        step(0, 0, 1, 32'h100, 0);
        expect_out("br_stall", 1, 32'h20, 0, 32'h20, BUB);
        step(0, 0, 0, 0, 0);
        expect_out("br_wait", 1, 32'h20, 0, 32'h20, BUB);
        step(0, 0, 0, 0, 1);
        expect_out("br_drop", 1, 32'h100, 0, 32'h20, BUB);
        step(0, 0, 0, 0, 1);
        expect_out("br_tgt", 1, 32'h104, 1, 32'h104, 32'hA5A5A4A5);

        // Branch in HOLD with freeze still high
        step(0, 1, 0, 0, 1);
        expect_out("hold2", 0, 32'h108, 1, 32'h104, 32'hA5A5A4A5);
        step(0, 1, 1, 32'h200, 1);
        expect_out("br_hold", 1, 32'h200, 0, 32'h104, BUB);
        step(0, 0, 0, 0, 1);
        expect_out("br_hold_tgt", 1, 32'h204, 1, 32'h204, 32'hA5A5A7A5);

        // Address wrap
        step(0, 0, 1, 32'hFFFF_FFF8, 1);
        expect_out("br_wrap", 1, 32'hFFFF_FFF8, 0, 32'h204, BUB);
        step(0, 0, 0, 0, 1);
        expect_out("pre_wrap", 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h5A5A5A5D);
        step(0, 0, 0, 0, 1);
        expect_out("wrap", 1, 32'h0, 1, 32'h0, 32'h5A5A5A59);

        // Reset in HOLD, then reset with a redirect pending
        step(0, 1, 0, 0, 1);
        expect_out("hold3", 0, 32'h4, 1, 32'h0, 32'h5A5A5A59);
        step(1, 1, 1, 32'h80, 1);
        expect_out("rst_hold", 0, RESET_PC, 0, 32'h0, BUB);
        step(0, 0, 1, 32'h300, 0);
        expect_out("pend_set", 1, RESET_PC, 0, 32'h0, BUB);
        step(1, 0, 0, 0, 1);
        expect_out("rst_pend", 0, RESET_PC, 0, 32'h0, BUB);
        step(0, 0, 0, 0, 1);
        expect_out("resume", 1, RESET_PC, 0, 32'h0, BUB);
        step(0, 0, 0, 0, 1);
        expect_out("resume_xfer", 1, 32'h4, 1, 32'h4, 32'hA5A5A5A5);
        step(0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
